// File: rtl/intr_ctrl.sv
// Parametrised interrupt controller: edge/level sources with software set and clear,
// sticky overflow, lowest-index priority ID and a pulse (rate-limited) or level CPU output.
module intr_ctrl #(
  parameter int                 NUM_SRC   = 8,
  parameter logic [NUM_SRC-1:0] SRC_EDGE  = '1,
  parameter bit                 PULSE_OUT = 1'b1,
  parameter int                 HOLDOFF_W = 4,
  parameter int                 ID_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 reset_i,
  input  logic [NUM_SRC-1:0]   intr_src_i,
  input  logic [NUM_SRC-1:0]   intr_set_i,
  input  logic [NUM_SRC-1:0]   intr_clear_i,
  input  logic [NUM_SRC-1:0]   intr_mask_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  output logic [NUM_SRC-1:0]   intr_status_o,
  output logic [NUM_SRC-1:0]   intr_ovf_o,
  output logic                 intr_pending_o,
  output logic [ID_W-1:0]      intr_id_o,
  output logic                 bus_intr_o
);

  logic [NUM_SRC-1:0]   r_src_q;
  logic [NUM_SRC-1:0]   r_status;
  logic [NUM_SRC-1:0]   r_ovf;
  logic [NUM_SRC-1:0]   r_pend_q;
  logic [ID_W-1:0]      r_id;
  logic                 r_bus;
  logic                 r_deferred;
  logic [HOLDOFF_W-1:0] r_cnt;

  logic [NUM_SRC-1:0]   w_ev;
  logic [NUM_SRC-1:0]   w_pend;
  logic [NUM_SRC-1:0]   w_rise;
  logic [ID_W-1:0]      w_id;
  logic                 w_fire;

  // Set by a rising edge (edge sources), by the level itself (level sources) or by software
  assign w_ev   = (SRC_EDGE & intr_src_i & ~r_src_q) | (~SRC_EDGE & intr_src_i) | intr_set_i;
  assign w_pend = r_status & intr_mask_i;
  assign w_rise = w_pend & ~r_pend_q;
  assign w_fire = (r_cnt == '0) && ((|w_rise) || (r_deferred && (|w_pend)));

  always_comb begin
    w_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_pend[i]) w_id = ID_W'(i);
    end
  end

  // src_q resets high so a source already asserted at reset release is not an edge
  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_src_q  <= '1;
      r_status <= '0;
      r_ovf    <= '0;
      r_pend_q <= '0;
      r_id     <= '0;
    end else begin
      r_src_q  <= intr_src_i;
      r_status <= (r_status | w_ev) & ~intr_clear_i;
      r_ovf    <= (r_ovf | (w_ev & r_status)) & ~intr_clear_i;
      r_pend_q <= w_pend;
      r_id     <= w_id;
    end
  end

  if (PULSE_OUT) begin : g_pulse
    // Rises during holdoff are remembered and served once the counter expires, if still pending
    always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
        r_bus      <= 1'b0;
        r_cnt      <= '0;
        r_deferred <= 1'b0;
      end else if (w_fire) begin
        r_bus      <= 1'b1;
        r_cnt      <= holdoff_i;
        r_deferred <= 1'b0;
      end else begin
        r_bus <= 1'b0;
        if (r_cnt != '0) begin
          r_cnt      <= r_cnt - 1'b1;
          r_deferred <= r_deferred | (|w_rise);
        end else begin
          r_deferred <= 1'b0;
        end
      end
    end
  end else begin : g_level
    always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
        r_bus      <= 1'b0;
        r_cnt      <= '0;
        r_deferred <= 1'b0;
      end else begin
        r_bus      <= |w_pend;
        r_cnt      <= '0;
        r_deferred <= 1'b0;
      end
    end
  end

  assign intr_status_o  = r_status;
  assign intr_ovf_o     = r_ovf;
  assign intr_pending_o = |w_pend;
  assign intr_id_o      = r_id;
  assign bus_intr_o     = r_bus;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: a pulse-mode and a level-mode instance share one stimulus and are
// checked each cycle against a time-based behavioural model, plus literal scenario checks.
module tb_intr_ctrl;

  localparam int         N    = 8;
  localparam logic [7:0] EDGE = 8'h5F;  // sources 5 and 7 are level triggered

  logic       clk = 1'b0;
  logic       reset_i;
  logic [7:0] src, set_s, clr, mask;
  logic [3:0] hold;

  logic [7:0] st_p, ovf_p, st_l, ovf_l;
  logic       pend_p, pend_l, bus_p, bus_l;
  logic [2:0] id_p, id_l;

  always #5 clk = ~clk;

  intr_ctrl #(.NUM_SRC(N), .SRC_EDGE(EDGE), .PULSE_OUT(1'b1), .HOLDOFF_W(4)) u_pulse (
    .clk(clk), .reset_i(reset_i), .intr_src_i(src), .intr_set_i(set_s),
    .intr_clear_i(clr), .intr_mask_i(mask), .holdoff_i(hold),
    .intr_status_o(st_p), .intr_ovf_o(ovf_p), .intr_pending_o(pend_p),
    .intr_id_o(id_p), .bus_intr_o(bus_p));

  intr_ctrl #(.NUM_SRC(N), .SRC_EDGE(EDGE), .PULSE_OUT(1'b0), .HOLDOFF_W(4)) u_level (
    .clk(clk), .reset_i(reset_i), .intr_src_i(src), .intr_set_i(set_s),
    .intr_clear_i(clr), .intr_mask_i(mask), .holdoff_i(hold),
    .intr_status_o(st_l), .intr_ovf_o(ovf_l), .intr_pending_o(pend_l),
    .intr_id_o(id_l), .bus_intr_o(bus_l));

  // Reference model: pulses are allowed once more than `holdoff` edges have passed since the last pulse
  logic [7:0] m_status, m_ovf, m_src_q, m_pend_q;
  logic [2:0] m_id;
  logic       m_bus_p, m_bus_l, m_seen;
  int         m_cyc, m_next_ok;

  always @(posedge clk or posedge reset_i) begin : model
    logic [7:0] ev, pend, rise;
    logic       fire;
    if (reset_i) begin
      m_status = '0; m_ovf = '0; m_src_q = '1; m_pend_q = '0; m_id = '0;
      m_bus_p = 1'b0; m_bus_l = 1'b0; m_seen = 1'b0; m_cyc = 0; m_next_ok = 0;
    end else begin
      for (int i = 0; i < N; i++)
        ev[i] = (EDGE[i] ? (src[i] && !m_src_q[i]) : src[i]) || set_s[i];
      pend = m_status & mask;
      rise = pend & ~m_pend_q;
      m_id = '0;
      for (int i = N - 1; i >= 0; i--)
        if (pend[i]) m_id = 3'(i);
      fire = (m_cyc >= m_next_ok) && ((rise != 0) || (m_seen && pend != 0));
      if (fire) begin
        m_bus_p = 1'b1; m_next_ok = m_cyc + int'(hold) + 1; m_seen = 1'b0;
      end else begin
        m_bus_p = 1'b0;
        if (m_cyc < m_next_ok) m_seen = m_seen || (rise != 0);
        else m_seen = 1'b0;
      end
      m_bus_l = (pend != 0);
      for (int i = 0; i < N; i++) begin
        if (clr[i]) begin
          m_status[i] = 1'b0; m_ovf[i] = 1'b0;
        end else begin
          if (ev[i] && m_status[i]) m_ovf[i] = 1'b1;
          if (ev[i]) m_status[i] = 1'b1;
        end
      end
      m_pend_q = pend;
      m_src_q  = src;
      m_cyc++;
    end
  end

  int checks = 0, errors = 0;
  int pulses = 0, cyc_n = 0, last_pc = 0, prev_pc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare every output with the model just after the edge, then return for driving
  task automatic tick();
    @(posedge clk);
    #1;
    cyc_n++;
    if (bus_p === 1'b1) begin
      pulses++; prev_pc = last_pc; last_pc = cyc_n;
    end
    chk("status_p", 32'(st_p), 32'(m_status));
    chk("ovf_p", 32'(ovf_p), 32'(m_ovf));
    chk("pending_p", 32'(pend_p), 32'(|(m_status & mask)));
    chk("id_p", 32'(id_p), 32'(m_id));
    chk("bus_p", 32'(bus_p), 32'(m_bus_p));
    chk("status_l", 32'(st_l), 32'(m_status));
    chk("id_l", 32'(id_l), 32'(m_id));
    chk("bus_l", 32'(bus_l), 32'(m_bus_l));
    #1;
  endtask

  task automatic clean();
    src = '0; set_s = '0; clr = '1;
    tick();
    clr = '0;
    repeat (18) tick();
  endtask

  int p0;

  initial begin
    reset_i = 1'b1;
    src = '0; set_s = '0; clr = '0; mask = '0; hold = '0;
    repeat (3) tick();
    chk("rst_status", 32'(st_p), 0);
    chk("rst_bus", 32'(bus_p), 0);
    chk("rst_id", 32'(id_p), 0);
    reset_i = 1'b0;
    tick();

    // Edge source 1 held high: one pulse only
    mask = 8'h02; p0 = pulses;
    src[1] = 1'b1;
    tick();
    chk("s1_status", 32'(st_p), 32'h02);
    repeat (6) tick();
    chk("s1_pulses", pulses - p0, 1);
    chk("s1_id", 32'(id_p), 1);
    chk("s1_level_bus", 32'(bus_l), 1);
    clean();

    // Masked event, later unmasked
    mask = 8'h00; p0 = pulses;
    src[3] = 1'b1; tick(); src[3] = 1'b0;
    repeat (3) tick();
    chk("s2_status", 32'(st_p), 32'h08);
    chk("s2_no_pulse", pulses - p0, 0);
    mask = 8'h08;
    repeat (3) tick();
    chk("s2_pulses", pulses - p0, 1);
    chk("s2_id", 32'(id_p), 3);
    clean();

    // Holdoff defers the second source
    hold = 4'd3; mask = 8'hFF; p0 = pulses;
    set_s = 8'h01; tick(); set_s = 8'h00; tick();
    set_s = 8'h04; tick(); set_s = 8'h00;
    repeat (8) tick();
    chk("s3_pulses", pulses - p0, 2);
    chk("s3_spacing", last_pc - prev_pc, 4);
    chk("s3_id", 32'(id_p), 0);
    clean();

    // Clear beats set; overflow on double set
    hold = 4'd0; mask = 8'hFF;
    set_s = 8'h10; clr = 8'h10; tick(); set_s = 8'h00; clr = 8'h00;
    chk("s4_clrwin_st", 32'(st_p[4]), 0);
    chk("s4_clrwin_ovf", 32'(ovf_p[4]), 0);
    p0 = pulses;
    set_s = 8'h10; tick(); set_s = 8'h00; tick();
    set_s = 8'h10; tick(); set_s = 8'h00; tick(); tick();
    chk("s4_ovf", 32'(ovf_p[4]), 1);
    chk("s4_pulses", pulses - p0, 1);
    clr = 8'h10; tick(); clr = 8'h00;
    chk("s4_clr_st", 32'(st_p[4]), 0);
    chk("s4_clr_ovf", 32'(ovf_p[4]), 0);
    clean();

    // Level source 5 re-asserts after clear
    mask = 8'h20; src[5] = 1'b1;
    repeat (3) tick();
    p0 = pulses;
    clr = 8'h20; tick(); clr = 8'h00;
    chk("s5_cleared", 32'(st_p[5]), 0);
    tick();
    chk("s5_reset", 32'(st_p[5]), 1);
    repeat (3) tick();
    chk("s5_pulses", pulses - p0, 1);
    clean();

    // Randomised traffic
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) src = 8'($urandom);
      set_s = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      clr   = ($urandom_range(0, 4) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      if ($urandom_range(0, 31) == 0) hold = 4'($urandom_range(0, 5));
      tick();
    end
    clean();

    // Asynchronous reset mid-holdoff with edge source 6 high
    hold = 4'd7; mask = 8'hFF;
    set_s = 8'h01; tick(); set_s = 8'h00; tick();
    src[6] = 1'b1;
    repeat (2) tick();
    #1 reset_i = 1'b1;
    #1;
    chk("s6_async_st", 32'(st_p), 0);
    chk("s6_async_ovf", 32'(ovf_p), 0);
    chk("s6_async_bus", 32'(bus_p), 0);
    chk("s6_async_id", 32'(id_p), 0);
    chk("s6_async_pend", 32'(pend_p), 0);
    chk("s6_async_st_l", 32'(st_l), 0);
    repeat (2) tick();
    reset_i = 1'b0;
    repeat (4) tick();
    chk("s6_no_edge", 32'(st_p[6]), 0);
    chk("s6_no_bus", 32'(bus_l), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
